// File: rtl/cacheline_adapter_pkg.sv
// Shared types for the cache/memory line adapter: FSM states and line geometry.
// Pure declarations; adds no latency or flow control of its own.
package rv32i_types;

    localparam int LINE_W        = 256;
    localparam int LINE_OFFSET_W = 5;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ_REQ  = 3'd2,
        READ_WAIT = 3'd3,
        RESP      = 3'd4,
        COOL      = 3'd5
    } adapter_state_t;

    // Clears the byte-within-line offset so bursts always start on a line boundary.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~((32'd1 << LINE_OFFSET_W) - 32'd1);
    endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Line-to-burst adapter: one 256-bit dfp read/write becomes a 4-beat bmem burst, then a 1-cycle dfp_resp.
// Write: beats 1..4 cycles after accept, resp next; read: resp the cycle after the last matching beat. Only beat 0 / the read request wait on bmem_ready.
module cacheline_adapter
    import rv32i_types::*;
#(
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         dfp_addr,
    input  logic                dfp_read,
    input  logic                dfp_write,
    input  logic [LINE_W-1:0]   dfp_wdata,
    output logic [LINE_W-1:0]   dfp_rdata,
    output logic                dfp_resp,
    output logic [31:0]         bmem_addr,
    output logic                bmem_read,
    output logic                bmem_write,
    output logic [BEAT_W-1:0]   bmem_wdata,
    input  logic                bmem_ready,
    input  logic [31:0]         bmem_raddr,
    input  logic [BEAT_W-1:0]   bmem_rdata,
    input  logic                bmem_rvalid
);

    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    adapter_state_t    state_q, state_d;
    logic [31:0]       addr_q,  addr_d;
    logic [LINE_W-1:0] line_q,  line_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic beat_issue;
    logic beat_match;

    // Beat 0 needs the memory to be ready; later beats of the burst stream unconditionally.
    assign beat_issue = (cnt_q != '0) || bmem_ready;
    assign beat_match = bmem_rvalid && (bmem_raddr == addr_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        line_d  = line_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (dfp_write) begin
                    addr_d  = line_align(dfp_addr);
                    line_d  = dfp_wdata;
                    cnt_d   = '0;
                    state_d = WRITE;
                end else if (dfp_read) begin
                    addr_d  = line_align(dfp_addr);
                    state_d = READ_REQ;
                end
            end
            WRITE: begin
                if (beat_issue) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                    end
                end
            end
            READ_REQ: begin
                if (bmem_ready) begin
                    cnt_d   = '0;
                    state_d = READ_WAIT;
                end
            end
            READ_WAIT: begin
                // Beats tagged for another line belong to someone else's burst.
                if (beat_match) begin
                    rdata_d[cnt_q*BEAT_W +: BEAT_W] = bmem_rdata;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = COOL;
            end
            COOL: begin
                // The cache drops its request during this cycle; do not re-sample it.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dfp_rdata  = rdata_q;
    assign dfp_resp   = (state_q == RESP);
    assign bmem_addr  = addr_q;
    assign bmem_read  = (state_q == READ_REQ);
    assign bmem_write = (state_q == WRITE);
    assign bmem_wdata = (state_q == WRITE) ? line_q[cnt_q*BEAT_W +: BEAT_W] : '0;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Bench for cacheline_adapter: table of directed transactions, hand-written reset sequences, then random traffic.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int n_vec = 0;
    int n_err = 0;
    logic [255:0] model_rdata;

    cacheline_adapter #(.BEAT_W(64), .BEATS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    typedef struct {
        bit          wr;
        bit          also_rd;
        logic [31:0] addr;
        logic [255:0] line;
        int          rdy_dly;
        int          gap0;
        int          gapn;
        bit          stray;
        logic [31:0] exp_addr;
        logic [63:0] exp_b0;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Reference model: beat k of a line is the k-th 64-bit word counted from the LSB.
    function automatic logic [63:0] beat_of(input logic [255:0] line, input int k);
        return 64'(line >> (64 * k));
    endfunction

    function automatic logic [31:0] align_of(input logic [31:0] a);
        return a - (a % 32);
    endfunction

    // Starts at a negedge with the adapter idle; returns at the negedge of the first idle cycle after COOL.
    task automatic run_write(input logic [31:0] addr, input logic [255:0] line, input int rdy_dly,
                             input logic [31:0] exp_addr, input logic [63:0] exp_b0,
                             input bit also_read, input logic [31:0] rd_addr);
        int k;
        int stalls;
        dfp_write   = 1'b1;
        dfp_read    = also_read;
        dfp_addr    = addr;
        dfp_wdata   = line;
        bmem_rvalid = 1'b0;
        @(negedge clk);
        dfp_wdata = rand256();
        chk("wr_beat0_value", 256'(bmem_wdata), 256'(exp_b0));
        k = 0;
        stalls = 0;
        while (k < 4) begin
            chk("wr_valid", 256'(bmem_write), 256'(1));
            chk("wr_addr", 256'(bmem_addr), 256'(exp_addr));
            chk("wr_beat", 256'(bmem_wdata), 256'(beat_of(line, k)));
            chk("wr_no_resp", 256'(dfp_resp), 256'(0));
            chk("wr_no_read", 256'(bmem_read), 256'(0));
            if (k == 0) bmem_ready = (stalls >= rdy_dly);
            else        bmem_ready = 1'($urandom_range(0, 1));
            if (k == 0 && !bmem_ready) stalls++;
            else                       k++;
            @(negedge clk);
        end
        if (also_read) dfp_addr = rd_addr;
        bmem_ready = 1'($urandom_range(0, 1));
        chk("wr_resp", 256'(dfp_resp), 256'(1));
        chk("wr_resp_no_beat", 256'(bmem_write), 256'(0));
        chk("wr_rdata_hold", dfp_rdata, model_rdata);
        @(negedge clk);
        chk("wr_cool_quiet", 256'({dfp_resp, bmem_read, bmem_write}), 256'(0));
        @(negedge clk);
        chk("wr_idle_quiet", 256'({dfp_resp, bmem_read, bmem_write}), 256'(0));
        dfp_write = 1'b0;
        if (!also_read) dfp_read = 1'b0;
    endtask

    task automatic run_read(input logic [31:0] addr, input logic [255:0] line, input int rdy_dly,
                            input int gap0, input int gapn, input bit stray,
                            input logic [31:0] exp_addr, input bit pre);
        int stalls;
        bit acc;
        int g;
        if (!pre) begin
            dfp_read  = 1'b1;
            dfp_write = 1'b0;
            dfp_addr  = addr;
        end
        bmem_rvalid = 1'b0;
        @(negedge clk);
        stalls = 0;
        acc = 1'b0;
        while (!acc) begin
            chk("rd_req", 256'(bmem_read), 256'(1));
            chk("rd_addr", 256'(bmem_addr), 256'(exp_addr));
            chk("rd_no_write", 256'(bmem_write), 256'(0));
            chk("rd_no_resp", 256'(dfp_resp), 256'(0));
            bmem_ready  = (stalls >= rdy_dly);
            bmem_rvalid = 1'b1;
            bmem_raddr  = exp_addr;
            bmem_rdata  = rand64();
            if (bmem_ready) acc = 1'b1;
            else            stalls++;
            @(negedge clk);
        end
        chk("rd_req_once", 256'(bmem_read), 256'(0));
        for (int k = 0; k < 4; k++) begin
            g = (k == 0) ? gap0 : gapn;
            for (int j = 0; j < g; j++) begin
                chk("rd_early_resp", 256'(dfp_resp), 256'(0));
                bmem_ready  = 1'($urandom_range(0, 1));
                bmem_rvalid = stray;
                bmem_raddr  = stray ? (exp_addr ^ 32'h0000_00C0) : exp_addr;
                bmem_rdata  = rand64();
                @(negedge clk);
            end
            chk("rd_early_resp", 256'(dfp_resp), 256'(0));
            bmem_rvalid = 1'b1;
            bmem_raddr  = exp_addr;
            bmem_rdata  = beat_of(line, k);
            @(negedge clk);
        end
        chk("rd_resp", 256'(dfp_resp), 256'(1));
        chk("rd_line", dfp_rdata, line);
        model_rdata = line;
        bmem_rdata  = rand64();
        @(negedge clk);
        chk("rd_cool_quiet", 256'({dfp_resp, bmem_read, bmem_write}), 256'(0));
        chk("rd_cool_hold", dfp_rdata, line);
        @(negedge clk);
        chk("rd_idle_quiet", 256'({dfp_resp, bmem_read, bmem_write}), 256'(0));
        chk("rd_idle_hold", dfp_rdata, line);
        dfp_read    = 1'b0;
        bmem_rvalid = 1'b0;
    endtask

    initial begin
        bit          wr;
        bit          ar;
        bit          pending;
        logic [31:0] a;
        logic [31:0] ra;
        logic [255:0] ln;

        tbl[0] = '{1'b1, 1'b0, 32'h0000_1234,
                   {32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1, 32'h0},
                   0, 0, 0, 1'b0, 32'h0000_1220, 64'h0000_0001_0000_0000};
        tbl[1] = '{1'b0, 1'b0, 32'h0000_0040,
                   {64'hA3, 64'hA2, 64'hA1, 64'hA0},
                   0, 10, 0, 1'b0, 32'h0000_0040, 64'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_2000,
                   {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000},
                   5, 0, 0, 1'b0, 32'h0000_2000, 64'hDEAD_BEEF_0000_0000};
        tbl[3] = '{1'b0, 1'b0, 32'h0000_0040,
                   {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0001},
                   5, 2, 1, 1'b1, 32'h0000_0040, 64'h0};
        tbl[4] = '{1'b1, 1'b1, 32'h0000_3010,
                   {64'hC3, 64'hC2, 64'hC1, 64'hC0},
                   1, 0, 0, 1'b0, 32'h0000_3000, 64'hC0};
        tbl[5] = '{1'b0, 1'b0, 32'h0000_3FE0,
                   {64'hB3, 64'hB2, 64'hB1, 64'hB0},
                   1, 0, 0, 1'b0, 32'h0000_3FE0, 64'h0};
        tbl[6] = '{1'b0, 1'b0, 32'hFFFF_FFFF,
                   {64'hFFFF_0000_FFFF_0003, 64'h2, 64'h1, 64'h0123_4567_89AB_CDEF},
                   0, 0, 0, 1'b0, 32'hFFFF_FFE0, 64'h0};

        rst         = 1'b0;
        dfp_addr    = '0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        dfp_wdata   = '0;
        bmem_ready  = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        model_rdata = '0;

        @(negedge clk);
        @(negedge clk);
        chk("reset_rdata", dfp_rdata, 256'(0));
        chk("reset_ctl", 256'({dfp_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata}), 256'(0));
        rst = 1'b1;
        @(negedge clk);

        pending = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].wr)
                run_write(tbl[i].addr, tbl[i].line, tbl[i].rdy_dly, tbl[i].exp_addr, tbl[i].exp_b0,
                          tbl[i].also_rd, (i < 6) ? tbl[i+1].addr : 32'h0);
            else
                run_read(tbl[i].addr, tbl[i].line, tbl[i].rdy_dly, tbl[i].gap0, tbl[i].gapn,
                         tbl[i].stray, tbl[i].exp_addr, pending);
            pending = tbl[i].wr && tbl[i].also_rd;
        end

        // Reset in the middle of a read burst, then stale beats while idle.
        dfp_read    = 1'b1;
        dfp_addr    = 32'h0000_0300;
        bmem_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bmem_rvalid = 1'b1;
        bmem_raddr  = 32'h0000_0300;
        bmem_rdata  = 64'h5A5A_5A5A_0000_0000;
        @(negedge clk);
        bmem_rdata  = 64'h5A5A_5A5A_0000_0001;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midread_rst_rdata", dfp_rdata, 256'(0));
        chk("midread_rst_ctl", 256'({dfp_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata}), 256'(0));
        dfp_read = 1'b0;
        model_rdata = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 4; j++) begin
            bmem_rdata = rand64();
            @(negedge clk);
            chk("stale_beat_ignored", 256'({dfp_resp, bmem_read, bmem_write}), 256'(0));
            chk("stale_beat_rdata", dfp_rdata, 256'(0));
        end
        bmem_rvalid = 1'b0;
        run_read(32'h0000_0300, rand256(), 2, 3, 1, 1'b1, 32'h0000_0300, 1'b0);

        // Reset in the middle of a write burst.
        dfp_write  = 1'b1;
        dfp_addr   = 32'h0000_0500;
        dfp_wdata  = rand256();
        bmem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midwrite_active", 256'(bmem_write), 256'(1));
        #2 rst = 1'b0;
        #1;
        chk("midwrite_rst_ctl", 256'({dfp_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata}), 256'(0));
        chk("midwrite_rst_rdata", dfp_rdata, 256'(0));
        dfp_write = 1'b0;
        model_rdata = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 256'({dfp_resp, bmem_read, bmem_write}), 256'(0));

        for (int t = 0; t < 30; t++) begin
            wr = 1'($urandom_range(0, 1));
            a  = $urandom;
            ln = rand256();
            if (wr) begin
                ar = ($urandom_range(0, 3) == 0);
                ra = $urandom;
                run_write(a, ln, $urandom_range(0, 4), align_of(a), beat_of(ln, 0), ar, ra);
                if (ar)
                    run_read(ra, rand256(), $urandom_range(0, 4), $urandom_range(0, 6),
                             $urandom_range(0, 2), 1'($urandom_range(0, 1)), align_of(ra), 1'b1);
            end else begin
                run_read(a, ln, $urandom_range(0, 4), $urandom_range(0, 6),
                         $urandom_range(0, 2), 1'($urandom_range(0, 1)), align_of(a), 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
